// File: rtl/alarma_pkg.sv
// alarma_pkg: shared FSM encoding, default parameters and prescaler width helper for the temperature alarm
package alarma_pkg;
  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    SOSPECHA = 2'd1,
    ALARMA   = 2'd2,
    RECUPERA = 2'd3
  } estado_t;
  localparam int N_CONFIRMA_DEF = 3;
  localparam int N_LIBERA_DEF = 2;
  localparam int DIV_PARPADEO_DEF = 25_000_000;
  function automatic int ancho_pre(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/alarma_temp_if.sv
// alarma_temp_if: comparator-side inputs and indicator/status outputs of the temperature alarm
interface alarma_temp_if #(parameter int ANCHO_EVT = 8);
  logic                 muestra_valida;
  logic                 fuera_rango;
  logic                 reconocer;
  logic                 alarma;
  logic                 reconocida;
  logic                 led_alarma;
  logic [1:0]           estado;
  logic [ANCHO_EVT-1:0] num_eventos;
  modport master (
    output muestra_valida, fuera_rango, reconocer,
    input  alarma, reconocida, led_alarma, estado, num_eventos
  );
  modport slave (
    input  muestra_valida, fuera_rango, reconocer,
    output alarma, reconocida, led_alarma, estado, num_eventos
  );
endinterface

// File: rtl/divisor_parpadeo.sv
// divisor_parpadeo: LED blink phase; toggles every DIV cycles while enabled, parks high otherwise
module divisor_parpadeo
  import alarma_pkg::*;
#(
  parameter int DIV = DIV_PARPADEO_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic habilita,
  output logic fase
);
  localparam int W = ancho_pre(DIV);
  localparam logic [W-1:0] TOPE = W'(DIV - 1);
  logic [W-1:0] pre;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre  <= '0;
      fase <= 1'b0;
    end else if (!habilita) begin
      pre  <= '0;
      fase <= 1'b1;
    end else begin
      pre  <= (pre == TOPE) ? '0 : pre + 1'b1;
      fase <= (pre == TOPE) ? ~fase : fase;
    end
  end
endmodule

// File: rtl/alarma_temp.sv
// alarma_temp: debounces the out-of-range flag, latches the alarm, handles acknowledge, LED and event count
module alarma_temp
  import alarma_pkg::*;
#(
  parameter int N_CONFIRMA   = N_CONFIRMA_DEF,
  parameter int N_LIBERA     = N_LIBERA_DEF,
  parameter int DIV_PARPADEO = DIV_PARPADEO_DEF,
  parameter int ANCHO_EVT    = 8
) (
  input  logic clk,
  input  logic rst_n,
  alarma_temp_if.slave bus
);
  localparam int CW = $clog2((N_CONFIRMA > N_LIBERA ? N_CONFIRMA : N_LIBERA) + 1);
  estado_t              estado_q, estado_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 evento;
  logic                 alarma;
  logic                 reconocida_q, reconocida_d;
  logic [ANCHO_EVT-1:0] num_q;
  logic                 fase;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q     <= NORMAL;
      cnt_q        <= '0;
      reconocida_q <= 1'b0;
      num_q        <= '0;
    end else begin
      estado_q     <= estado_d;
      cnt_q        <= cnt_d;
      reconocida_q <= reconocida_d;
      num_q        <= (evento && !(&num_q)) ? num_q + 1'b1 : num_q;
    end
  end
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    evento   = 1'b0;
    if (bus.muestra_valida) begin
      case (estado_q)
        NORMAL: begin
          estado_d = bus.fuera_rango ? SOSPECHA : NORMAL;
          cnt_d    = bus.fuera_rango ? CW'(1) : '0;
        end
        SOSPECHA: begin
          if (!bus.fuera_rango) begin
            estado_d = NORMAL;
            cnt_d    = '0;
          end else if (int'(cnt_q) + 1 == N_CONFIRMA) begin
            estado_d = ALARMA;
            cnt_d    = '0;
            evento   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ALARMA: begin
          estado_d = bus.fuera_rango ? ALARMA : RECUPERA;
          cnt_d    = bus.fuera_rango ? cnt_q : CW'(1);
        end
        RECUPERA: begin
          if (bus.fuera_rango) begin
            estado_d = ALARMA;
            cnt_d    = '0;
          end else if (int'(cnt_q) + 1 == N_LIBERA) begin
            estado_d = NORMAL;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end
  always_comb begin
    alarma       = (estado_q == ALARMA) || (estado_q == RECUPERA);
    reconocida_d = (estado_d == NORMAL || estado_d == SOSPECHA) ? 1'b0
                 : reconocida_q | (bus.reconocer & alarma);
  end
  divisor_parpadeo #(.DIV(DIV_PARPADEO)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .habilita (alarma & ~reconocida_q),
    .fase     (fase)
  );
  assign bus.alarma      = alarma;
  assign bus.reconocida  = reconocida_q;
  assign bus.led_alarma  = alarma & (reconocida_q | fase);
  assign bus.estado      = estado_q;
  assign bus.num_eventos = num_q;
endmodule

// File: tb/tb_alarma_temp.sv
// tb_alarma_temp: directed steps with a scoreboard of expected outputs checked one edge after each step
module tb_alarma_temp;
  typedef struct {
    logic [1:0] e;
    logic       a;
    logic       rc;
    logic       led;
    logic [1:0] n;
    int         id;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   id = 0;
  exp_t sb[$];
  alarma_temp_if #(.ANCHO_EVT(2)) bus ();
  alarma_temp #(
    .N_CONFIRMA   (3),
    .N_LIBERA     (2),
    .DIV_PARPADEO (4),
    .ANCHO_EVT    (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int sid, input logic [1:0] obs, input logic [1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step %0d observed=%0d expected=%0d", tag, sid, obs, expv);
    end
  endtask
  task automatic comparar();
    exp_t x;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty step %0d observed=0 expected=1", id);
    end
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("estado", x.id, bus.estado, x.e);
      chk("alarma", x.id, {1'b0, bus.alarma}, {1'b0, x.a});
      chk("reconocida", x.id, {1'b0, bus.reconocida}, {1'b0, x.rc});
      chk("led_alarma", x.id, {1'b0, bus.led_alarma}, {1'b0, x.led});
      chk("num_eventos", x.id, bus.num_eventos, x.n);
    end
  endtask
  task automatic paso(input logic rn, input logic v, input logic f, input logic r,
                      input logic [1:0] e, input logic a, input logic rc, input logic led,
                      input logic [1:0] n);
    id++;
    sb.push_back('{e, a, rc, led, n, id});
    rst_n              = rn;
    bus.muestra_valida = v;
    bus.fuera_rango    = f;
    bus.reconocer      = r;
    @(posedge clk);
    #1;
    comparar();
  endtask
  initial begin
    rst_n = 1'b0;
    bus.muestra_valida = 1'b0;
    bus.fuera_rango = 1'b0;
    bus.reconocer = 1'b0;
    paso(0, 0, 0, 0, 0, 0, 0, 0, 0);
    paso(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // glitch: two out-of-range samples then one in range, idle cycle between
    paso(1, 1, 1, 0, 1, 0, 0, 0, 0);
    paso(1, 0, 1, 0, 1, 0, 0, 0, 0);
    paso(1, 1, 1, 0, 1, 0, 0, 0, 0);
    paso(1, 1, 0, 0, 0, 0, 0, 0, 0);
    paso(1, 0, 0, 1, 0, 0, 0, 0, 0);
    // raise with idle cycles in between: run count must survive them
    paso(1, 1, 1, 1, 1, 0, 0, 0, 0);
    paso(1, 0, 1, 0, 1, 0, 0, 0, 0);
    paso(1, 1, 1, 0, 1, 0, 0, 0, 0);
    paso(1, 0, 0, 0, 1, 0, 0, 0, 0);
    paso(1, 1, 1, 0, 2, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) paso(1, 0, 0, 0, 2, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) paso(1, 0, 0, 0, 2, 1, 0, 0, 1);
    paso(1, 0, 0, 0, 2, 1, 0, 1, 1);
    paso(1, 1, 1, 0, 2, 1, 0, 1, 1);
    // acknowledge, then bounce back to ALARMA and recover
    paso(1, 0, 0, 1, 2, 1, 1, 1, 1);
    for (int i = 0; i < 5; i++) paso(1, 0, 0, 0, 2, 1, 1, 1, 1);
    paso(1, 1, 0, 0, 3, 1, 1, 1, 1);
    paso(1, 1, 1, 0, 2, 1, 1, 1, 1);
    paso(1, 1, 0, 0, 3, 1, 1, 1, 1);
    paso(1, 1, 0, 0, 0, 0, 0, 0, 1);
    // saturation of the event counter
    for (int i = 0; i < 3; i++) begin
      logic [1:0] nx;
      nx = (i >= 1) ? 2'd3 : 2'(i + 2);
      paso(1, 1, 1, 0, 1, 0, 0, 0, nx == 2'd3 && i >= 2 ? 2'd3 : 2'(nx - 1));
      paso(1, 1, 1, 0, 1, 0, 0, 0, nx == 2'd3 && i >= 2 ? 2'd3 : 2'(nx - 1));
      paso(1, 1, 1, 0, 2, 1, 0, 1, nx);
      paso(1, 1, 0, 0, 3, 1, 0, 1, nx);
      paso(1, 1, 0, 0, 0, 0, 0, 0, nx);
    end
    // reset while recovering
    paso(1, 1, 1, 0, 1, 0, 0, 0, 3);
    paso(1, 1, 1, 0, 1, 0, 0, 0, 3);
    paso(1, 1, 1, 0, 2, 1, 0, 1, 3);
    paso(1, 1, 0, 1, 3, 1, 1, 1, 3);
    paso(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // acknowledge on the clearing sample: NORMAL wins
    paso(1, 1, 1, 0, 1, 0, 0, 0, 0);
    paso(1, 1, 1, 0, 1, 0, 0, 0, 0);
    paso(1, 1, 1, 0, 2, 1, 0, 1, 1);
    paso(1, 1, 0, 0, 3, 1, 0, 1, 1);
    paso(1, 1, 0, 1, 0, 0, 0, 0, 1);
    paso(1, 0, 0, 1, 0, 0, 0, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout step %0d observed=running expected=finished", id);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alarma_temp.md
Name: alarma_temp

Overview:
- Downstream consumer of the combinational out-of-range flag produced by the temperature comparator.
- Debounces that flag over consecutive valid samples, raises and holds a latched alarm, and accepts an operator acknowledge.
- Drives a blinking/steady alarm LED and a saturating count of alarm events.
- Sits between the comparator and the board-level indicators/status register.

Parameters:
- N_CONFIRMA, 3, consecutive out-of-range valid samples needed to raise alarm (legal range ≥2).
- N_LIBERA, 2, consecutive in-range valid samples needed to clear alarm (legal range ≥2).
- DIV_PARPADEO, 25_000_000, clock cycles per LED half-period while alarm is unacknowledged (legal range ≥1).
- ANCHO_EVT, 8, width of the event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- muestra_valida  input  1  one-cycle strobe; fuera_rango is sampled only when this is high.
- fuera_rango  input  1  out-of-range flag from the comparator.
- reconocer  input  1  operator acknowledge, level or pulse, sampled every cycle.
- alarma  output  1  high in ALARMA and RECUPERA.
- reconocida  output  1  high once the current alarm has been acknowledged.
- led_alarma  output  1  alarm LED drive.
- estado  output  2  current FSM state encoding.
- num_eventos  output  ANCHO_EVT  saturating count of alarm entries.

Behaviour:
- All state is registered. Reset is synchronous, active-low, on clk: when rst_n=0 at a clock edge, the FSM goes to NORMAL and every output and internal counter clears to 0.
- Clock and reset: one clock (clk); reset rst_n is synchronous and active-low.
- Sample cycles: a sample counts only in cycles where muestra_valida=1. Cycles with muestra_valida=0 change no FSM state and no run counter.
- Latency: a transition caused by a sample at edge k is visible on outputs immediately after edge k (1-cycle registered latency).
- FSM states: NORMAL=0, SOSPECHA=1, ALARMA=2, RECUPERA=3. A run counter cnt tracks consecutive samples.
- NORMAL:
  - valid & fuera → SOSPECHA, cnt=1.
  - valid & !fuera → stay, cnt=0.
- SOSPECHA:
  - valid & fuera: if cnt+1==N_CONFIRMA → ALARMA, cnt=0, num_eventos+1 (saturates at all-ones); else cnt+1.
  - valid & !fuera → NORMAL, cnt=0.
- ALARMA:
  - valid & !fuera → RECUPERA, cnt=1.
  - valid & fuera → stay.
- RECUPERA:
  - valid & !fuera: if cnt+1==N_LIBERA → NORMAL, cnt=0; else cnt+1.
  - valid & fuera → ALARMA, cnt=0. This is not a new event: no increment, reconocida is kept.
- Acknowledge:
  - reconocer=1 while alarma=1 sets reconocida on the next edge.
  - reconocer is ignored in NORMAL/SOSPECHA.
  - reconocida clears on entry to NORMAL.
  - If an acknowledge and the clearing sample occur in the same cycle, the transition to NORMAL wins and reconocida=0.
- LED:
  - Internal phase bit fase and prescaler pre.
  - While alarma & !reconocida: pre counts 0..DIV_PARPADEO-1; at wrap, fase toggles.
  - Otherwise pre=0 and fase=1.
  - led_alarma = alarma & (reconocida | fase).
  - On alarm entry the LED is on immediately, toggles after DIV_PARPADEO cycles, and goes steady on once acknowledged.
- num_eventos: never wraps; holds at 2^ANCHO_EVT-1.
- Reset mid-alarm: reset always returns the block to NORMAL with every output at 0, regardless of the current state.

Decomposition:
- alarma_pkg holds:
  - the estado_t enum (2-bit, encodings above);
  - default constants for N_CONFIRMA, N_LIBERA and DIV_PARPADEO;
  - a function computing the prescaler width via $clog2(DIV_PARPADEO).
- One sub-module, divisor_parpadeo (inputs: clk, rst_n, habilita; output: fase; parameter DIV), owns pre and fase.
- The FSM, run counter, acknowledge flag and event counter remain in alarma_temp.

Test Plan (N_CONFIRMA=3, N_LIBERA=2, DIV_PARPADEO=4, ANCHO_EVT=2):
- Reset: hold rst_n=0 for 2 cycles → alarma=0, led_alarma=0, estado=0, num_eventos=0.
- Raise: 3 valid samples with fuera=1 → estado 1, 1, 2; alarma=1 after the 3rd edge; num_eventos=1; led_alarma=1 for 4 cycles, then 0 for 4, then 1.
- Glitch rejection: valid fuera=1,1,0 → estado returns to 0; no alarm; num_eventos unchanged. Valid=0 cycles in between leave cnt unchanged.
- Acknowledge and recovery:
  - reconocer pulse in ALARMA → reconocida=1, led_alarma steady 1.
  - valid fuera=0, 1 → back to ALARMA; reconocida still 1; num_eventos unchanged.
  - valid fuera=0, 0 → NORMAL; reconocida=0; led=0.
- Saturation: 4 complete alarm cycles → num_eventos=3 (saturated); a 5th cycle leaves it at 3.
- Reset mid-operation and simultaneous events:
  - rst_n=0 in RECUPERA → next cycle all outputs 0.
  - reconocer=1 coinciding with the 2nd in-range sample → NORMAL, reconocida=0.
